// File: rtl/axis_pkt_trailer.sv
// Forwards AXI-Stream packets unchanged and appends one trailer beat per packet
// carrying {beat count, 32-bit additive checksum of masked data}.
//
// state   | meaning
// PASS    | forwarding data beats, accumulating count and checksum
// TRAILER | last data beat taken; waiting for output register to load trailer
module axis_pkt_trailer #(
    parameter int TDATA_WIDTH = 64,
    parameter int TDATA_BYTES = TDATA_WIDTH / 8
) (
    input  logic                   s_axis_aclk,
    input  logic                   s_axis_areset,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [TDATA_BYTES-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TDATA_BYTES-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [15:0]            pkt_count
);

    typedef enum logic [0:0] {PASS, TRAILER} state_t;

    state_t                   state, state_next;
    logic                     out_free;
    logic                     accept;
    logic                     load_data;
    logic                     load_trailer;
    logic [TDATA_WIDTH-1:0]   masked;
    logic [31:0]              beat_sum;
    logic [31:0]              beat_cnt, beat_cnt_next;
    logic [31:0]              csum, csum_next;
    logic [63:0]              trailer;

    assign out_free      = !m_axis_tvalid || m_axis_tready;
    // Held low during reset so upstream never handshakes into a clearing block.
    assign s_axis_tready = (state == PASS) && out_free && !s_axis_areset;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        masked = '0;
        for (int i = 0; i < TDATA_BYTES; i++) begin
            masked[i*8 +: 8] = s_axis_tkeep[i] ? s_axis_tdata[i*8 +: 8] : 8'h00;
        end
    end

    assign beat_sum      = masked[31:0] + masked[63:32];
    assign beat_cnt_next = beat_cnt + 32'd1;
    assign csum_next     = csum + beat_sum;

    always_comb begin
        state_next   = state;
        load_data    = 1'b0;
        load_trailer = 1'b0;
        case (state)
            PASS: begin
                if (accept) begin
                    load_data = 1'b1;
                    if (s_axis_tlast) state_next = TRAILER;
                end
            end
            TRAILER: begin
                if (out_free) begin
                    load_trailer = 1'b1;
                    state_next   = PASS;
                end
            end
            default: state_next = PASS;
        endcase
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state <= PASS;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (load_data) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
        end else if (load_trailer) begin
            m_axis_tdata  <= trailer;
            m_axis_tkeep  <= '1;
            m_axis_tlast  <= 1'b1;
            m_axis_tvalid <= 1'b1;
        end else if (out_free) begin
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            beat_cnt <= '0;
            csum     <= '0;
            trailer  <= '0;
        end else if (load_data) begin
            beat_cnt <= beat_cnt_next;
            csum     <= csum_next;
            if (s_axis_tlast) trailer <= {beat_cnt_next, csum_next};
        end else if (load_trailer) begin
            beat_cnt <= '0;
            csum     <= '0;
        end
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            pkt_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_axis_pkt_trailer.sv
// Directed bench for axis_pkt_trailer: hand-computed trailers, backpressure,
// back-to-back packets and reset mid-packet.
module tb_axis_pkt_trailer;

    logic        clk;
    logic        rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [15:0] pkt_count;

    int total = 0;
    int bad   = 0;

    logic [72:0] out_q[$];
    int          stall_viol = 0;
    logic        stalled_prev = 1'b0;
    logic [72:0] held = '0;

    axis_pkt_trailer #(.TDATA_WIDTH(64), .TDATA_BYTES(8)) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .pkt_count     (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: records handshaked beats and flags changes while stalled.
    always @(negedge clk) begin
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev && ({m_tlast, m_tkeep, m_tdata} !== held || m_tvalid !== 1'b1))
                stall_viol++;
            if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tkeep, m_tdata});
            stalled_prev = m_tvalid && !m_tready;
            held = {m_tlast, m_tkeep, m_tdata};
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_q.delete();
        stall_viol = 0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             output int waits);
        bit done = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        waits = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (s_tready) done = 1;
            else waits++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL send_timeout: s_tready stayed 0, required handshake for beat %h", d);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int cycles);
        s_tvalid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [72:0] exp[$]);
        total++;
        if (out_q.size() !== exp.size()) begin
            bad++;
            $display("FAIL %s_count: got %0d beats, required %0d", name, out_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp[i]) begin
                bad++;
                $display("FAIL %s_beat%0d: got last=%b keep=%h data=%h, required last=%b keep=%h data=%h",
                         name, i, out_q[i][72], out_q[i][71:64], out_q[i][63:0],
                         exp[i][72], exp[i][71:64], exp[i][63:0]);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
            bad++; $display("FAIL reset_valid_last: got %b%b, required 00", m_tvalid, m_tlast);
        end
        total++;
        if (m_tdata !== 64'h0 || m_tkeep !== 8'h0) begin
            bad++; $display("FAIL reset_data_keep: got %h/%h, required 0/0", m_tdata, m_tkeep);
        end
        total++;
        if (s_tready !== 1'b0) begin
            bad++; $display("FAIL reset_s_tready: got %b, required 0", s_tready);
        end
        total++;
        if (pkt_count !== 16'd0) begin
            bad++; $display("FAIL reset_pkt_count: got %0d, required 0", pkt_count);
        end
    endtask

    task automatic test_three_beat();
        logic [72:0] exp[$];
        int w;
        do_reset();
        send_beat(64'h0000000000020001, 8'hFF, 1'b0, w);
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== 64'h0000000000020001) begin
            bad++; $display("FAIL latency: got valid=%b data=%h, required 1/0000000000020001", m_tvalid, m_tdata);
        end
        send_beat(64'h0000000000020101, 8'hFF, 1'b0, w);
        send_beat(64'h000000070000000D, 8'hFF, 1'b1, w);
        drain(6);
        exp.push_back({1'b0, 8'hFF, 64'h0000000000020001});
        exp.push_back({1'b0, 8'hFF, 64'h0000000000020101});
        exp.push_back({1'b0, 8'hFF, 64'h000000070000000D});
        exp.push_back({1'b1, 8'hFF, 64'h0000000300040116});
        check_out("three_beat", exp);
        total++;
        if (pkt_count !== 16'd1) begin
            bad++; $display("FAIL three_beat_pkt_count: got %0d, required 1", pkt_count);
        end
    endtask

    task automatic test_wrap();
        logic [72:0] exp[$];
        int w;
        do_reset();
        send_beat(64'hFFFFFFFF00000001, 8'hFF, 1'b1, w);
        drain(5);
        exp.push_back({1'b0, 8'hFF, 64'hFFFFFFFF00000001});
        exp.push_back({1'b1, 8'hFF, 64'h0000000100000000});
        check_out("wrap", exp);
    endtask

    task automatic test_partial_keep();
        logic [72:0] exp[$];
        int w;
        do_reset();
        send_beat(64'h1122334455667788, 8'h0F, 1'b1, w);
        drain(5);
        exp.push_back({1'b0, 8'h0F, 64'h1122334455667788});
        exp.push_back({1'b1, 8'hFF, 64'h0000000155667788});
        check_out("partial_keep", exp);
    endtask

    task automatic test_backpressure();
        logic [72:0] exp[$];
        do_reset();
        fork
            begin
                int w;
                for (int b = 1; b <= 5; b++)
                    send_beat({32'h0, 32'(b)}, 8'hFF, (b == 5), w);
                s_tvalid = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    m_tready = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk); #1;
                end
                m_tready = 1'b1;
            end
        join
        drain(4);
        for (int b = 1; b <= 5; b++) exp.push_back({1'b0, 8'hFF, {32'h0, 32'(b)}});
        exp.push_back({1'b1, 8'hFF, 64'h000000050000000F});
        check_out("backpressure", exp);
        total++;
        if (stall_viol !== 0) begin
            bad++; $display("FAIL backpressure_stable: got %0d changes while stalled, required 0", stall_viol);
        end
        total++;
        if (pkt_count !== 16'd1) begin
            bad++; $display("FAIL backpressure_pkt_count: got %0d, required 1", pkt_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [72:0] exp[$];
        int w;
        int waits_sum = 0;
        do_reset();
        send_beat(64'h1, 8'hFF, 1'b0, w);  waits_sum += w;
        send_beat(64'h2, 8'hFF, 1'b1, w);  waits_sum += w;
        send_beat(64'h10, 8'hFF, 1'b0, w); waits_sum += w;
        send_beat(64'h20, 8'hFF, 1'b1, w); waits_sum += w;
        total++;
        if (waits_sum !== 1) begin
            bad++; $display("FAIL b2b_dip_between: got %0d stall cycles, required 1", waits_sum);
        end
        @(negedge clk);
        total++;
        if (s_tready !== 1'b0) begin
            bad++; $display("FAIL b2b_dip_trailer: got s_tready=%b, required 0", s_tready);
        end
        @(negedge clk);
        total++;
        if (s_tready !== 1'b1) begin
            bad++; $display("FAIL b2b_dip_recover: got s_tready=%b, required 1", s_tready);
        end
        s_tvalid = 1'b0;
        drain(4);
        exp.push_back({1'b0, 8'hFF, 64'h1});
        exp.push_back({1'b0, 8'hFF, 64'h2});
        exp.push_back({1'b1, 8'hFF, 64'h0000000200000003});
        exp.push_back({1'b0, 8'hFF, 64'h10});
        exp.push_back({1'b0, 8'hFF, 64'h20});
        exp.push_back({1'b1, 8'hFF, 64'h0000000200000030});
        check_out("b2b", exp);
        total++;
        if (pkt_count !== 16'd2) begin
            bad++; $display("FAIL b2b_pkt_count: got %0d, required 2", pkt_count);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [72:0] exp[$];
        int w;
        do_reset();
        send_beat(64'h0000000100000001, 8'hFF, 1'b0, w);
        send_beat(64'h0000000200000002, 8'hFF, 1'b0, w);
        s_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            bad++; $display("FAIL midreset_drop: got m_tvalid=%b s_tready=%b, required 0/0", m_tvalid, s_tready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_q.delete();
        send_beat(64'h0000000000000005, 8'hFF, 1'b1, w);
        drain(5);
        exp.push_back({1'b0, 8'hFF, 64'h0000000000000005});
        exp.push_back({1'b1, 8'hFF, 64'h0000000100000005});
        check_out("midreset", exp);
        total++;
        if (pkt_count !== 16'd1) begin
            bad++; $display("FAIL midreset_pkt_count: got %0d, required 1", pkt_count);
        end
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        test_reset();
        test_three_beat();
        test_wrap();
        test_partial_keep();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
